nios_system_sdram_nios2_qsys_0_oci_dct_sequencer: RTL and testbench

Sequences the OCI data-compressed-trace (DCT) path. It packs 2-bit trace atoms into the 30-bit dct_buffer and tracks occupancy in dct_count. It moves full or flushed buffers into a one-deep hold register and drains them to trace memory over a valid/ready handshake. On test_ending it force-flushes the buffer, drains the hold register, and raises test_has_ended.

---
 rtl/nios_system_sdram_nios2_qsys_0_oci_dct_sequencer.sv | 131 +++++++++++++
 tb/tb_nios_system_sdram_nios2_qsys_0_oci_dct_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nios_system_sdram_nios2_qsys_0_oci_dct_sequencer.sv
// OCI data-compressed-trace sequencer: packs 2-bit atoms into a 15-slot buffer,
// moves full or flushed buffers into a one-deep hold register, drains them over
// a valid/ready handshake, and runs an end-of-test drain that ends in a sticky
// test_has_ended flag.
module nios_system_sdram_nios2_qsys_0_oci_dct_sequencer #(
  parameter int ATOM_W = 2,
  parameter int SLOTS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           trc_enable,
  input  logic                           atom_valid,
  input  logic [ATOM_W-1:0]              atom_data,
  output logic                           atom_ready,
  input  logic                           flush_req,
  input  logic                           test_ending,
  output logic [ATOM_W*SLOTS-1:0]        dct_buffer,
  output logic [CNT_W-1:0]               dct_count,
  output logic                           tw_valid,
  output logic [CNT_W+2+ATOM_W*SLOTS-1:0] tw_data,
  input  logic                           tw_ready,
  output logic                           test_has_ended
);

  localparam int BUF_W = ATOM_W * SLOTS;
  localparam int TW_W  = CNT_W + 2 + BUF_W;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [BUF_W-1:0]    dct_buffer_r;
  logic [CNT_W-1:0]    dct_count_r;
  logic                tw_valid_r;
  logic [TW_W-1:0]     tw_data_r;
  logic                test_has_ended_r;
  logic                flush_pending_r;

  logic                full_s;
  logic                empty_s;
  logic                flush_s;
  logic                xfer_s;
  logic                accept_s;
  logic                handshake_s;
  logic                flush_set_s;
  logic                flush_clr_s;

  assign full_s      = (dct_count_r == CNT_W'(SLOTS));
  assign empty_s     = (dct_count_r == {CNT_W{1'b0}});
  // DRAIN keeps forcing the flush even if test_ending is withdrawn.
  assign flush_s     = flush_pending_r || (state_r == DRAIN);
  assign xfer_s      = (full_s || (flush_s && !empty_s)) && (!tw_valid_r || tw_ready);
  assign atom_ready  = trc_enable && (state_r == FILL) && (dct_count_r < CNT_W'(SLOTS))
                       && !flush_pending_r;
  assign accept_s    = atom_valid && atom_ready;
  assign handshake_s = tw_valid_r && tw_ready;
  assign flush_set_s = flush_req || (test_ending && !test_has_ended_r);
  assign flush_clr_s = xfer_s || empty_s;

  assign dct_buffer     = dct_buffer_r;
  assign dct_count      = dct_count_r;
  assign tw_valid       = tw_valid_r;
  assign tw_data        = tw_data_r;
  assign test_has_ended = test_has_ended_r;

  // Next-state logic for the FILL -> DRAIN -> DONE end-of-test sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FILL: begin
        if (test_ending) state_s = DRAIN;
        else             state_s = FILL;
      end
      DRAIN: begin
        if (empty_s && !tw_valid_r) state_s = DONE;
        else                        state_s = DRAIN;
      end
      DONE:    state_s = DONE;
      default: state_s = FILL;
    endcase
  end

  // State register and sticky end-of-test flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= FILL;
      test_has_ended_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s == DONE) test_has_ended_r <= 1'b1;
    end
  end

  // Flush request latch; a new request wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pending_r <= 1'b0;
    end else if (flush_set_s) begin
      flush_pending_r <= 1'b1;
    end else if (flush_clr_s) begin
      flush_pending_r <= 1'b0;
    end
  end

  // Atom packing, buffer-to-hold transfer and hold-register drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer_r <= {BUF_W{1'b0}};
      dct_count_r  <= {CNT_W{1'b0}};
      tw_valid_r   <= 1'b0;
      tw_data_r    <= {TW_W{1'b0}};
    end else if (xfer_s) begin
      tw_data_r    <= {dct_count_r, 2'b00, dct_buffer_r};
      tw_valid_r   <= 1'b1;
      dct_buffer_r <= {BUF_W{1'b0}};
      dct_count_r  <= {CNT_W{1'b0}};
    end else begin
      if (handshake_s) tw_valid_r <= 1'b0;
      if (accept_s) begin
        dct_buffer_r[dct_count_r*ATOM_W +: ATOM_W] <= atom_data;
        dct_count_r <= dct_count_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nios_system_sdram_nios2_qsys_0_oci_dct_sequencer.sv
// Directed bench for the DCT sequencer with hand-computed expected words.
module tb_nios_system_sdram_nios2_qsys_0_oci_dct_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        trc_enable = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'b00;
  logic        atom_ready;
  logic        flush_req = 1'b0;
  logic        test_ending = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        tw_valid;
  logic [35:0] tw_data;
  logic        tw_ready = 1'b0;
  logic        test_has_ended;

  int tests_run = 0;
  int tests_failed = 0;

  nios_system_sdram_nios2_qsys_0_oci_dct_sequencer dut (
    .clk(clk), .reset_n(reset_n), .trc_enable(trc_enable),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
    .flush_req(flush_req), .test_ending(test_ending),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .tw_valid(tw_valid), .tw_data(tw_data), .tw_ready(tw_ready),
    .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] d);
    atom_valid = 1'b1;
    atom_data  = d;
    step();
    atom_valid = 1'b0;
  endtask

  initial begin
    // reset values
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_count", 36'(dct_count), 36'd0);
    check_eq("rst_buffer", 36'(dct_buffer), 36'd0);
    check_eq("rst_tw_valid", 36'(tw_valid), 36'd0);
    check_eq("rst_tw_data", tw_data, 36'd0);
    check_eq("rst_ended", 36'(test_has_ended), 36'd0);
    #19 reset_n = 1'b1;
    step();

    // full buffer with free hold register
    trc_enable = 1'b1;
    tw_ready   = 1'b1;
    for (int i = 0; i < 15; i++) accept(2'b01);
    check_eq("full_count", 36'(dct_count), 36'd15);
    check_eq("full_no_valid_yet", 36'(tw_valid), 36'd0);
    step();
    check_eq("full_tw_valid", 36'(tw_valid), 36'd1);
    check_eq("full_tw_data", tw_data, 36'hF_1555_5555);
    check_eq("full_count_clr", 36'(dct_count), 36'd0);
    step();
    check_eq("full_drained", 36'(tw_valid), 36'd0);

    // back-pressure: second full buffer waits for the hold register
    tw_ready = 1'b0;
    for (int i = 0; i < 15; i++) accept(2'b10);
    step();
    check_eq("bp_first_held", tw_data, 36'hF_2AAA_AAAA);
    for (int i = 0; i < 15; i++) accept(2'b11);
    atom_valid = 1'b1;
    atom_data  = 2'b11;
    #1;
    check_eq("bp_ready_low", 36'(atom_ready), 36'd0);
    step();
    atom_valid = 1'b0;
    check_eq("bp_count_holds", 36'(dct_count), 36'd15);
    check_eq("bp_data_stable", tw_data, 36'hF_2AAA_AAAA);
    tw_ready = 1'b1;
    step();
    check_eq("bp_b2b_valid", 36'(tw_valid), 36'd1);
    check_eq("bp_b2b_data", tw_data, 36'hF_3FFF_FFFF);
    check_eq("bp_count_clr", 36'(dct_count), 36'd0);
    check_eq("bp_ready_back", 36'(atom_ready), 36'd1);
    step();
    check_eq("bp_drained", 36'(tw_valid), 36'd0);

    // partial flush, last atom accepted with the flush request
    accept(2'b11);
    accept(2'b10);
    flush_req = 1'b1;
    accept(2'b01);
    flush_req = 1'b0;
    check_eq("fl_count", 36'(dct_count), 36'd3);
    step();
    check_eq("fl_tw_valid", 36'(tw_valid), 36'd1);
    check_eq("fl_tw_data", tw_data, 36'h3_0000_001B);
    step();
    check_eq("fl_drained", 36'(tw_valid), 36'd0);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check_eq("fl_empty_a", 36'(tw_valid), 36'd0);
    step();
    check_eq("fl_empty_b", 36'(tw_valid), 36'd0);
    check_eq("fl_empty_ready", 36'(atom_ready), 36'd1);

    // trc_enable low blocks acceptance only
    accept(2'b01);
    accept(2'b11);
    trc_enable = 1'b0;
    atom_valid = 1'b1;
    atom_data  = 2'b10;
    for (int i = 0; i < 10; i++) step();
    check_eq("en_ready_low", 36'(atom_ready), 36'd0);
    check_eq("en_buffer", 36'(dct_buffer), 36'h0_0000_000D);
    check_eq("en_count", 36'(dct_count), 36'd2);
    atom_valid = 1'b0;
    trc_enable = 1'b1;

    // async reset with a held word and a partly packed buffer
    tw_ready  = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    check_eq("ar_held", tw_data, 36'h2_0000_000D);
    for (int i = 0; i < 7; i++) accept(2'b10);
    check_eq("ar_count7", 36'(dct_count), 36'd7);
    check_eq("ar_valid1", 36'(tw_valid), 36'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("ar_count", 36'(dct_count), 36'd0);
    check_eq("ar_buffer", 36'(dct_buffer), 36'd0);
    check_eq("ar_tw_valid", 36'(tw_valid), 36'd0);
    check_eq("ar_tw_data", tw_data, 36'd0);
    #10 reset_n = 1'b1;
    step();

    // end-of-test drain
    for (int i = 0; i < 5; i++) accept(2'b01);
    test_ending = 1'b1;
    step();
    check_eq("te_ready_low", 36'(atom_ready), 36'd0);
    step();
    check_eq("te_tw_valid", 36'(tw_valid), 36'd1);
    check_eq("te_tw_data", tw_data, 36'h5_0000_0155);
    test_ending = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("te_still_held", 36'(tw_valid), 36'd1);
    check_eq("te_not_ended", 36'(test_has_ended), 36'd0);
    tw_ready = 1'b1;
    step();
    check_eq("te_handshake", 36'(tw_valid), 36'd0);
    check_eq("te_ended_wait", 36'(test_has_ended), 36'd0);
    step();
    check_eq("te_ended", 36'(test_has_ended), 36'd1);
    atom_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("te_sticky", 36'(test_has_ended), 36'd1);
    check_eq("te_done_ready", 36'(atom_ready), 36'd0);
    check_eq("te_done_count", 36'(dct_count), 36'd0);
    check_eq("te_done_valid", 36'(tw_valid), 36'd0);
    atom_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
